// File: rtl/sfu_seq_ctrl.sv
// Two-pass SFU sequencer: ACC pass streams rows into the SFU statistics, NORM pass
// re-reads each row, waits out the read+SFU latency and writes the result back in place.
module sfu_seq_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int RD_LAT  = 1,
    parameter int SFU_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_sfu,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    output logic [ADDR_W-1:0] psum_mem_addr,
    output logic              psum_mem_rd_enable,
    output logic              psum_mem_wr_enable,
    output logic              sfu_clear,
    output logic              sfu_acc_en,
    output logic              sfu_norm_en,
    output logic              sfu_active,
    output logic              sfu_done
);

    localparam int W = RD_LAT + SFU_LAT;
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(W - 1);
    localparam logic [ADDR_W-1:0] WAIT_LAST  = ADDR_W'(W - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACC_RD, S_ACC_DRAIN,
        S_NORM_RD, S_NORM_WAIT, S_NORM_WR, S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q, rows_q, idx_q, cnt_q, addr_q;
    logic              acc_rd_q, norm_rd_q, wr_q, clear_q, done_q;
    logic [RD_LAT-1:0] acc_dly_q, norm_dly_q;
    logic [ADDR_W-1:0] idx_inc_d, row_addr_d, next_addr_d;
    logic              cancel_d;

    assign idx_inc_d   = idx_q + ADDR_W'(1);
    assign row_addr_d  = base_q + idx_q;
    assign next_addr_d = base_q + idx_inc_d;
    assign cancel_d    = abort && (state_q != S_IDLE);

    // Outputs are registered: each transition loads the strobes of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            acc_rd_q  <= 1'b0;
            norm_rd_q <= 1'b0;
            wr_q      <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_rd_q  <= 1'b0;
            norm_rd_q <= 1'b0;
            wr_q      <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            if (cancel_d) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_sfu) begin
                            base_q <= base_addr;
                            rows_q <= num_rows;
                            idx_q  <= '0;
                            cnt_q  <= '0;
                            if (num_rows == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_CLEAR;
                                clear_q <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        state_q  <= S_ACC_RD;
                        acc_rd_q <= 1'b1;
                        addr_q   <= row_addr_d;
                        idx_q    <= idx_inc_d;
                    end
                    S_ACC_RD: begin
                        // idx_q counts reads already issued
                        if (idx_q == rows_q) begin
                            state_q <= S_ACC_DRAIN;
                            cnt_q   <= '0;
                        end else begin
                            acc_rd_q <= 1'b1;
                            addr_q   <= row_addr_d;
                            idx_q    <= idx_inc_d;
                        end
                    end
                    S_ACC_DRAIN: begin
                        if (cnt_q == DRAIN_LAST) begin
                            state_q   <= S_NORM_RD;
                            norm_rd_q <= 1'b1;
                            addr_q    <= base_q;
                            idx_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                    S_NORM_RD: begin
                        state_q <= S_NORM_WAIT;
                        cnt_q   <= '0;
                    end
                    S_NORM_WAIT: begin
                        if (cnt_q == WAIT_LAST) begin
                            state_q <= S_NORM_WR;
                            wr_q    <= 1'b1;
                            addr_q  <= row_addr_d;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                    S_NORM_WR: begin
                        if (idx_inc_d == rows_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_NORM_RD;
                            norm_rd_q <= 1'b1;
                            addr_q    <= next_addr_d;
                            idx_q     <= idx_inc_d;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Read strobes delayed by RD_LAT to line up with data arriving at sfu_in.
    always_ff @(posedge clk) begin
        if (reset || cancel_d) begin
            acc_dly_q  <= '0;
            norm_dly_q <= '0;
        end else begin
            acc_dly_q  <= RD_LAT'({acc_dly_q, acc_rd_q});
            norm_dly_q <= RD_LAT'({norm_dly_q, norm_rd_q});
        end
    end

    assign psum_mem_addr      = addr_q;
    assign psum_mem_rd_enable = acc_rd_q | norm_rd_q;
    assign psum_mem_wr_enable = wr_q;
    assign sfu_clear          = clear_q;
    assign sfu_acc_en         = acc_dly_q[RD_LAT-1];
    assign sfu_norm_en        = norm_dly_q[RD_LAT-1];
    assign sfu_active         = (state_q != S_IDLE);
    assign sfu_done           = done_q;

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Scoreboard bench for sfu_seq_ctrl: directed runs push hand-timed strobe events,
// a negedge monitor pops and compares every cycle in which any strobe is high.
module tb_sfu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start_sfu, abort;
    logic [10:0] base_addr, num_rows, psum_mem_addr;
    logic        psum_mem_rd_enable, psum_mem_wr_enable, sfu_clear;
    logic        sfu_acc_en, sfu_norm_en, sfu_active, sfu_done;

    sfu_seq_ctrl #(.ADDR_W(11), .RD_LAT(1), .SFU_LAT(2)) dut (
        .clk(clk), .reset(reset), .start_sfu(start_sfu), .abort(abort),
        .base_addr(base_addr), .num_rows(num_rows), .psum_mem_addr(psum_mem_addr),
        .psum_mem_rd_enable(psum_mem_rd_enable), .psum_mem_wr_enable(psum_mem_wr_enable),
        .sfu_clear(sfu_clear), .sfu_acc_en(sfu_acc_en), .sfu_norm_en(sfu_norm_en),
        .sfu_active(sfu_active), .sfu_done(sfu_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [5:0]  flags;  // {clr, rd, wr, acc, norm, done}
        logic [10:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  act_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ev(int t0, int rel, int upto, logic [5:0] f, logic [10:0] a);
        ev_t e;
        if (rel <= upto) begin
            e.cyc = t0 + rel; e.flags = f; e.addr = a;
            exp_q.push_back(e);
        end
    endtask

    // Hand-timed 3-row run (RD_LAT=1, SFU_LAT=2), events after rel cycle 'upto' dropped.
    task automatic push_std(int t0, logic [10:0] a0, a1, a2, int upto);
        ev(t0, 1,  upto, 6'b100000, 11'd0);
        ev(t0, 2,  upto, 6'b010000, a0);
        ev(t0, 3,  upto, 6'b010100, a1);
        ev(t0, 4,  upto, 6'b010100, a2);
        ev(t0, 5,  upto, 6'b000100, 11'd0);
        ev(t0, 8,  upto, 6'b010000, a0);
        ev(t0, 9,  upto, 6'b000010, 11'd0);
        ev(t0, 11, upto, 6'b001000, a0);
        ev(t0, 12, upto, 6'b010000, a1);
        ev(t0, 13, upto, 6'b000010, 11'd0);
        ev(t0, 15, upto, 6'b001000, a1);
        ev(t0, 16, upto, 6'b010000, a2);
        ev(t0, 17, upto, 6'b000010, 11'd0);
        ev(t0, 19, upto, 6'b001000, a2);
        ev(t0, 20, upto, 6'b000001, 11'd0);
    endtask

    always @(negedge clk) begin
        logic [5:0] f;
        ev_t e;
        f = {sfu_clear, psum_mem_rd_enable, psum_mem_wr_enable, sfu_acc_en, sfu_norm_en, sfu_done};
        if (sfu_active === 1'b1) act_cnt++;
        if (reset === 1'b0) begin
            n_checks++;
            if ((psum_mem_rd_enable & psum_mem_wr_enable) !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_wr_excl cyc=%0d rd=%b wr=%b required not both", cyc,
                         psum_mem_rd_enable, psum_mem_wr_enable);
            end
            n_checks++;
            if (prev_done === 1'b1 && sfu_done === 1'b1) begin
                n_fail++;
                $display("FAIL done_pulse cyc=%0d done high two cycles, required single pulse", cyc);
            end
        end
        prev_done = sfu_done;
        if (|f === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d flags=%b addr=%0d required none", cyc, f,
                         psum_mem_addr);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.flags !== f ||
                    ((f[4] | f[3]) && psum_mem_addr !== e.addr)) begin
                    n_fail++;
                    $display("FAIL event cyc=%0d flags=%b addr=%0d required cyc=%0d flags=%b addr=%0d",
                             cyc, f, psum_mem_addr, e.cyc, e.flags, e.addr);
                end
            end
        end
    end

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_at(int c, logic [10:0] b, logic [10:0] n);
        wait_until(c);
        base_addr = b; num_rows = n; start_sfu = 1'b1;
        @(posedge clk); #1;
        start_sfu = 1'b0;
    endtask

    task automatic check_idle_outs(string name);
        logic [16:0] v;
        v = {psum_mem_addr, psum_mem_rd_enable, psum_mem_wr_enable, sfu_clear, sfu_acc_en,
             sfu_norm_en, sfu_active};
        n_checks++;
        if (v[5:0] !== 6'b0) begin
            n_fail++;
            $display("FAIL %s strobes/active=%b required 000000", name, v[5:0]);
        end
        n_checks++;
        if (sfu_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done=%b required 0", name, sfu_done);
        end
    endtask

    task automatic check_drained(string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing %0d expected events not seen, required 0 (next cyc=%0d)",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        int t0;
        reset = 1'b1; start_sfu = 1'b0; abort = 1'b0; base_addr = '0; num_rows = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle_outs("reset");
        n_checks++;
        if (psum_mem_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_addr addr=%0d required 0", psum_mem_addr);
        end

        // 1: base=4 rows=3
        t0 = cyc + 2;
        push_std(t0, 11'd4, 11'd5, 11'd6, 99);
        start_at(t0, 11'd4, 11'd3);
        wait_until(t0 + 24);
        check_drained("s1");

        // 2: rows=0 -> done only, active one cycle
        act_cnt = 0;
        t0 = cyc + 2;
        ev(t0, 1, 99, 6'b000001, 11'd0);
        start_at(t0, 11'd9, 11'd0);
        wait_until(t0 + 6);
        check_drained("s2");
        n_checks++;
        if (act_cnt != 1) begin
            n_fail++;
            $display("FAIL s2_active cycles=%0d required 1", act_cnt);
        end

        // 3: address wrap
        t0 = cyc + 2;
        push_std(t0, 11'd2046, 11'd2047, 11'd0, 99);
        start_at(t0, 11'd2046, 11'd3);
        wait_until(t0 + 24);
        check_drained("s3");

        // 4: abort in NORM_WAIT, then clean restart
        t0 = cyc + 2;
        push_std(t0, 11'd4, 11'd5, 11'd6, 13);
        start_at(t0, 11'd4, 11'd3);
        wait_until(t0 + 13);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outs("s4_abort_idle");
        wait_until(t0 + 16);
        check_drained("s4a");
        push_std(t0 + 16, 11'd4, 11'd5, 11'd6, 99);
        start_at(t0 + 16, 11'd4, 11'd3);
        wait_until(t0 + 16 + 24);
        check_drained("s4b");

        // 5: start re-pulsed mid-run with different operands
        t0 = cyc + 2;
        push_std(t0, 11'd4, 11'd5, 11'd6, 99);
        start_at(t0, 11'd4, 11'd3);
        start_at(t0 + 6, 11'd100, 11'd7);
        start_at(t0 + 10, 11'd200, 11'd1);
        wait_until(t0 + 24);
        check_drained("s5");

        // 6: reset mid-run
        t0 = cyc + 2;
        push_std(t0, 11'd4, 11'd5, 11'd6, 9);
        start_at(t0, 11'd4, 11'd3);
        wait_until(t0 + 9);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outs("s6_reset_idle");
        n_checks++;
        if (psum_mem_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL s6_reset_addr addr=%0d required 0", psum_mem_addr);
        end
        wait_until(t0 + 24);
        check_drained("s6");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
